// File: rtl/bus_alu_seq.sv
// Sequential 2-bit ALU that reads operands A and B in turn from a shared 3-state bus.
// It then holds the registered result until downstream accepts it. Define BUS_ALU_OPCNT_EN to add the op_count output.
module bus_alu_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] bus_in,
  output logic       oe_a_n,
  output logic       oe_b_n,
  output logic [1:0] result,
  output logic       carry,
  output logic       zero,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready
`ifdef BUS_ALU_OPCNT_EN
  ,
  output logic [7:0] op_count
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] a_reg;
  logic [1:0] b_reg;
  logic [1:0] op_reg;
  logic [2:0] alu_sum;
  logic [1:0] alu_res;
  logic       alu_carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The bus enables are decoded from the state, so only one register can ever drive bus_in at a time.
  always_comb begin
    state_next = state;
    oe_a_n     = 1'b1;
    oe_b_n     = 1'b1;
    busy       = 1'b1;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = RD_A;
      end
      RD_A: begin
        oe_a_n     = 1'b0;
        state_next = RD_B;
      end
      RD_B: begin
        oe_b_n     = 1'b0;
        state_next = EXEC;
      end
      EXEC: state_next = HOLD;
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_sum   = {1'b0, a_reg} + {1'b0, b_reg};
    alu_res   = 2'b00;
    alu_carry = 1'b0;
    case (op_reg)
      2'b00: begin
        alu_res   = alu_sum[1:0];
        alu_carry = alu_sum[2];
      end
      2'b01: begin
        alu_res   = a_reg - b_reg;
        alu_carry = (a_reg < b_reg);
      end
      2'b10: alu_res = a_reg & b_reg;
      default: alu_res = a_reg ^ b_reg;
    endcase
  end

  // Outputs only change at the end of EXEC, so they stay put through HOLD and the following IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= 2'b00;
      b_reg  <= 2'b00;
      op_reg <= 2'b00;
      result <= 2'b00;
      carry  <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) op_reg <= op;
        RD_A: a_reg <= bus_in;
        RD_B: b_reg <= bus_in;
        EXEC: begin
          result <= alu_res;
          carry  <= alu_carry;
          zero   <= (alu_res == 2'b00);
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_ALU_OPCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= 8'd0;
    end else if (state == HOLD && res_ready && op_count != 8'hFF) begin
      op_count <= op_count + 8'd1;
    end
  end
`endif

endmodule
